// File: rtl/prefetch_queue.sv
// prefetch_queue: small FIFO of line-aligned prefetch addresses that feeds a
// single-outstanding fill engine. Pushes that duplicate a queued, outstanding
// or concurrently demanded line are absorbed. Demand misses cancel matching
// queued entries in place. Every absorbed or cancelled prefetch is counted in
// a saturating drop counter.
module prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LINE_BITS = 6,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [63:0]      pf_address_i,
    input  logic             pf_valid_i,
    output logic             pf_ready_o,
    input  logic [63:0]      demand_address_i,
    input  logic             demand_valid_i,
    output logic [63:0]      mem_req_address_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    input  logic             mem_resp_valid_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] dropped_count_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned LINE_W = 64 - LINE_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_t;

    // Queue storage: line address plus a live bit; a cancelled entry keeps its
    // slot and is discarded when it reaches the head.
    logic [LINE_W-1:0] line_q [DEPTH];
    logic [DEPTH-1:0]  live_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [OCC_W-1:0]  count_q;
    logic [OCC_W-1:0]  count_d;
    logic              ready_q;
    logic              ready_d;

    // Issue engine
    state_t            state_q;
    state_t            state_d;
    logic [LINE_W-1:0] req_line_q;

    // Drop accounting
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W-1:0]  drop_d;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;

    // Per-cycle decode
    logic [LINE_W-1:0] pf_line;
    logic [LINE_W-1:0] dm_line;
    logic              pf_hit_live;
    logic [DEPTH-1:0]  cancel_vec;
    logic              cancel_any;
    logic              outstanding;
    logic              push;
    logic              dup;
    logic              store;
    logic              head_live;
    logic              pop;
    logic              issue;
    logic [DEPTH-1:0]  pop_oh;
    logic [DEPTH-1:0]  store_oh;

    // Byte offsets within a line play no part in matching or issuing.
    logic unused_offsets;
    assign unused_offsets = ^{pf_address_i[LINE_BITS-1:0], demand_address_i[LINE_BITS-1:0]};

    assign pf_line = pf_address_i[63:LINE_BITS];
    assign dm_line = demand_address_i[63:LINE_BITS];

    // Compare incoming prefetch and demand lines against every live entry
    always_comb begin
        pf_hit_live = 1'b0;
        cancel_vec  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (line_q[i] == pf_line)) begin
                pf_hit_live = 1'b1;
            end
            if (demand_valid_i && live_q[i] && (line_q[i] == dm_line)) begin
                cancel_vec[i] = 1'b1;
            end
        end
    end

    assign outstanding = (state_q != StIdle);
    assign cancel_any  = |cancel_vec;
    assign push        = pf_valid_i && ready_q;

    // A duplicate is accepted (handshake completes) but never stored.
    assign dup = push && (pf_hit_live
                          || (outstanding && (req_line_q == pf_line))
                          || (demand_valid_i && (dm_line == pf_line)));
    assign store = push && !dup;

    // A head entry cancelled this very cycle is treated as dead, so the demand
    // wins over a same-cycle issue.
    assign head_live = live_q[rd_ptr_q] && !cancel_vec[rd_ptr_q];

    // Issue FSM next-state: pop the head from idle, hold the request until
    // accepted, then wait for the fill to complete
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_live) begin
                        issue   = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // One-hot slot selects for the pop and the store
    always_comb begin
        pop_oh   = '0;
        store_oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pop_oh[i]   = pop && (rd_ptr_q == PTR_W'(i));
            store_oh[i] = store && (wr_ptr_q == PTR_W'(i));
        end
    end

    // Ready looks at occupancy after this edge, so a pop only frees a slot
    // for the following cycle.
    assign count_d = count_q + OCC_W'(store) - OCC_W'(pop);
    assign ready_d = (count_d < OCC_W'(DEPTH));

    // Up to two drop events per cycle, clamped at all-ones
    assign drop_inc = {1'b0, cancel_any} + {1'b0, dup};
    assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);
    assign drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

    // Queue entries: cancel or pop kills an entry; a store fills a free slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
            live_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cancel_vec[i] || pop_oh[i]) begin
                    live_q[i] <= 1'b0;
                end
                if (store_oh[i]) begin
                    line_q[i] <= pf_line;
                    live_q[i] <= 1'b1;
                end
            end
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy and ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (store) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // Issue state and the latched request line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            req_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                req_line_q <= line_q[rd_ptr_q];
            end
        end
    end

    // Saturating drop counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign pf_ready_o        = ready_q;
    assign mem_req_valid_o   = (state_q == StReq);
    assign mem_req_address_o = {req_line_q, {LINE_BITS{1'b0}}};
    assign busy_o            = (count_q != '0) || outstanding;
    assign dropped_count_o   = drop_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a queue-based reference model is compared with the
// DUT on every falling edge, and directed scenarios add literal expectations.
module tb_prefetch_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LB      = 6;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_MAX = 65535;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [63:0]       pf_address = '0;
    logic              pf_valid = 1'b0;
    logic              pf_ready;
    logic [63:0]       demand_address = '0;
    logic              demand_valid = 1'b0;
    logic [63:0]       mem_req_address;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_resp_valid = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  dropped_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    prefetch_queue #(
        .DEPTH     (DEPTH),
        .LINE_BITS (LB),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pf_address_i      (pf_address),
        .pf_valid_i        (pf_valid),
        .pf_ready_o        (pf_ready),
        .demand_address_i  (demand_address),
        .demand_valid_i    (demand_valid),
        .mem_req_address_o (mem_req_address),
        .mem_req_valid_o   (mem_req_valid),
        .mem_req_ready_i   (mem_req_ready),
        .mem_resp_valid_i  (mem_resp_valid),
        .busy_o            (busy),
        .dropped_count_o   (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] line;
        bit          live;
    } ent_t;

    ent_t        m_q[$];
    bit          m_ready    = 1'b0;
    bit          m_pending  = 1'b0;  // a fill has been taken from the queue
    bit          m_accepted = 1'b0;  // memory has accepted that fill
    logic [63:0] m_req_line = '0;
    int unsigned m_drops    = 0;

    task automatic model_reset();
        m_q.delete();
        m_ready    = 1'b0;
        m_pending  = 1'b0;
        m_accepted = 1'b0;
        m_req_line = '0;
        m_drops    = 0;
    endtask

    task automatic model_step();
        logic [63:0] pl;
        logic [63:0] dl;
        bit          push;
        bit          dup;
        bit          hit;
        int unsigned ev;
        ent_t        e;
        pl   = pf_address >> LB;
        dl   = demand_address >> LB;
        push = pf_valid && m_ready;
        dup  = 1'b0;
        hit  = 1'b0;
        ev   = 0;
        if (push) begin
            foreach (m_q[i]) if (m_q[i].live && m_q[i].line == pl) dup = 1'b1;
            if (m_pending && m_req_line == pl) dup = 1'b1;
            if (demand_valid && dl == pl) dup = 1'b1;
        end
        if (demand_valid) begin
            foreach (m_q[i]) begin
                if (m_q[i].live && m_q[i].line == dl) begin
                    m_q[i].live = 1'b0;
                    hit = 1'b1;
                end
            end
        end
        if (hit) ev++;
        if (dup) ev++;
        if (!m_pending) begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                if (e.live) begin
                    m_pending  = 1'b1;
                    m_accepted = 1'b0;
                    m_req_line = e.line;
                end
            end
        end else if (!m_accepted) begin
            if (mem_req_ready) m_accepted = 1'b1;
        end else if (mem_resp_valid) begin
            m_pending = 1'b0;
        end
        if (push && !dup) m_q.push_back('{line: pl, live: 1'b1});
        m_ready = (m_q.size() < DEPTH);
        m_drops = (m_drops + ev > CNT_MAX) ? CNT_MAX : m_drops + ev;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk1("cmp_ready", pf_ready, m_ready);
                chk1("cmp_valid", mem_req_valid, m_pending && !m_accepted);
                if (m_pending && !m_accepted) chk("cmp_addr", mem_req_address, m_req_line << LB);
                chk1("cmp_busy", busy, (m_q.size() != 0) || m_pending);
                chk("cmp_drops", 64'(dropped_count), 64'(m_drops));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] a);
        int g = 0;
        pf_address = a;
        pf_valid   = 1'b1;
        while (!pf_ready && g < 50) begin
            step();
            g++;
        end
        chk1("push_ready", pf_ready, 1'b1);
        step();
        pf_valid = 1'b0;
    endtask

    // Wait for a fill request, check its address, then accept and complete it.
    task automatic expect_fill(input string name, input logic [63:0] a);
        int g = 0;
        while (!mem_req_valid && g < 20) begin
            step();
            g++;
        end
        chk1({name, "_valid"}, mem_req_valid, 1'b1);
        chk({name, "_addr"}, mem_req_address, a);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset state
        step();
        step();
        chk1("rst_ready", pf_ready, 1'b0);
        chk1("rst_valid", mem_req_valid, 1'b0);
        chk("rst_addr", mem_req_address, 64'h0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_drops", 64'(dropped_count), 64'h0);
        rst = 1'b0;
        check_en = 1'b1;
        chk1("rel_ready_before_edge", pf_ready, 1'b0);
        step();
        chk1("rel_ready_after_edge", pf_ready, 1'b1);

        // Basic issue and latency
        push(64'h1000_0047);
        chk1("basic_valid_early", mem_req_valid, 1'b0);
        chk1("basic_busy_queued", busy, 1'b1);
        step();
        chk1("basic_valid", mem_req_valid, 1'b1);
        chk("basic_addr", mem_req_address, 64'h1000_0040);
        step();
        chk1("basic_valid_held", mem_req_valid, 1'b1);
        chk("basic_addr_held", mem_req_address, 64'h1000_0040);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk1("basic_wait_valid", mem_req_valid, 1'b0);
        chk1("basic_wait_busy", busy, 1'b1);
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk1("basic_idle_busy", busy, 1'b0);

        // Full queue and backpressure, FIFO order across pointer wrap
        push(64'h4000);
        push(64'h4040);
        push(64'h4080);
        push(64'h40C0);
        push(64'h4100);
        chk1("bp_full_ready", pf_ready, 1'b0);
        chk1("bp_first_valid", mem_req_valid, 1'b1);
        chk("bp_first_addr", mem_req_address, 64'h4000);
        pf_address = 64'h4140;
        pf_valid   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("bp_held_ready", pf_ready, 1'b0);
        end
        expect_fill("bp_a", 64'h4000);
        step();
        chk1("bp_ready_after_pop", pf_ready, 1'b1);
        step();
        pf_valid = 1'b0;
        chk1("bp_full_again", pf_ready, 1'b0);
        expect_fill("bp_b", 64'h4040);
        expect_fill("bp_c", 64'h4080);
        expect_fill("bp_d", 64'h40C0);
        expect_fill("bp_e", 64'h4100);
        expect_fill("bp_f", 64'h4140);
        chk1("bp_drained_busy", busy, 1'b0);
        chk("bp_no_drops", 64'(dropped_count), 64'h0);

        // Duplicate filter: same line queued, then outstanding
        push(64'h2000);
        push(64'h2010);
        push(64'h2000);
        chk("dup_drops", 64'(dropped_count), 64'h2);
        expect_fill("dup", 64'h2000);
        step();
        chk1("dup_single_fill", mem_req_valid, 1'b0);
        chk1("dup_idle_busy", busy, 1'b0);

        // Demand cancel of a queued line; demand on the outstanding line
        push(64'h3000);
        push(64'h3040);
        demand_address = 64'h3044;
        demand_valid   = 1'b1;
        step();
        demand_valid = 1'b0;
        chk("cancel_drops", 64'(dropped_count), 64'h3);
        demand_address = 64'h3000;
        demand_valid   = 1'b1;
        step();
        demand_valid = 1'b0;
        chk("cancel_outstanding_drops", 64'(dropped_count), 64'h3);
        chk1("cancel_not_retracted", mem_req_valid, 1'b1);
        expect_fill("cancel", 64'h3000);
        chk1("cancel_dead_head_busy", busy, 1'b1);
        step();
        chk1("cancel_no_issue", mem_req_valid, 1'b0);
        chk1("cancel_idle_busy", busy, 1'b0);

        // Saturation: bulk duplicates against the outstanding line
        push(64'h5000);
        push(64'h5040);
        chk("sat_start", 64'(dropped_count), 64'h3);
        pf_address = 64'h5000;
        pf_valid   = 1'b1;
        repeat (65531) step();
        chk("sat_near_max", 64'(dropped_count), 64'hFFFE);
        demand_address = 64'h5040;
        demand_valid   = 1'b1;
        step();
        demand_valid = 1'b0;
        chk("sat_plus_two", 64'(dropped_count), 64'hFFFF);
        step();
        pf_valid = 1'b0;
        chk("sat_no_wrap", 64'(dropped_count), 64'hFFFF);

        // Asynchronous reset while waiting for a fill
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk1("rw_wait_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rw_ready", pf_ready, 1'b0);
        chk1("rw_valid", mem_req_valid, 1'b0);
        chk("rw_addr", mem_req_address, 64'h0);
        chk1("rw_busy", busy, 1'b0);
        chk("rw_drops", 64'(dropped_count), 64'h0);
        step();
        step();
        rst = 1'b0;
        chk1("rw_ready_before_edge", pf_ready, 1'b0);
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk1("rw_ready_after_edge", pf_ready, 1'b1);
        chk1("rw_late_resp_busy", busy, 1'b0);
        step();
        chk1("rw_no_resume", mem_req_valid, 1'b0);

        // Normal operation after reset
        push(64'h6000_0005);
        expect_fill("post_rst", 64'h6000_0000);
        chk1("post_rst_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 4, queue entries (power of two, 2..16)
- LINE_BITS, 6, log2 line size in bytes; line address is addr[63:LINE_BITS]
- CNT_W, 16, dropped-request counter width
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- pf_address_i  in  64  prefetch address from prefetcher (its lo_prefetch_address_o)
- pf_valid_i  in  1  prefetch request valid (its lo_prefetch_valid_o)
- pf_ready_o  out  1  queue can accept; drives prefetcher's lo_ready_i
- demand_address_i  in  64  demand-miss address arriving at this lower-level cache
- demand_valid_i  in  1  demand-miss valid
- mem_req_address_o  out  64  line-aligned prefetch fill address (low LINE_BITS zero)
- mem_req_valid_o  out  1  fill request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_resp_valid_i  in  1  outstanding fill complete
- busy_o  out  1  queue non-empty or state not IDLE
- dropped_count_o  out  CNT_W  saturating count of dropped/cancelled prefetches

Function
REQ-003 Push SHALL occur on a cycle with pf_valid_i && pf_ready_o; the entry is stored line-aligned and marked live.
REQ-004 pf_ready_o SHALL be registered: 1 when occupancy after the current edge < DEPTH, else 0; a same-cycle pop does not raise it early.
REQ-005 Duplicate filter: a push whose line address matches any live entry, the outstanding request (state REQ or WAIT), or a same-cycle demand_valid_i line SHALL be accepted but not stored, and counted as one drop.
REQ-006 Demand cancel: demand_valid_i whose line matches a live queued entry SHALL clear that entry's live bit next edge and count one drop; the entry keeps its FIFO slot.
REQ-007 Demand matching the outstanding request in REQ or WAIT SHALL NOT retract it and SHALL NOT count a drop.
REQ-008 Issue FSM states SHALL be IDLE, REQ, WAIT.
REQ-009 IDLE: if head entry exists and live, latch its address into the request register, pop, go REQ.
REQ-010 IDLE: if head entry exists but not live, pop it and stay IDLE (one cycle, no issue).
REQ-011 IDLE: if queue empty, stay IDLE.
REQ-012 REQ: mem_req_valid_o=1, mem_req_address_o stable; on mem_req_ready_i go WAIT.
REQ-013 WAIT: mem_req_valid_o=0; on mem_resp_valid_i go IDLE.
REQ-014 mem_resp_valid_i outside WAIT SHALL be ignored.
REQ-015 Latency: live push at edge N into empty queue with FSM in IDLE SHALL give mem_req_valid_o=1 in cycle after edge N+1.
REQ-016 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-017 Read/write pointers SHALL wrap modulo DEPTH.
REQ-018 dropped_count_o SHALL increment by events per cycle (0..2), saturating at all-ones, never wrapping.
REQ-019 busy_o SHALL be combinational from registered state: (occupancy != 0) || (state != IDLE).

Reset
REQ-020 While rst_i=1 (asynchronously), all of the following SHALL hold:
- queue empty, all live bits 0, state IDLE
- pf_ready_o=0, mem_req_valid_o=0, mem_req_address_o=0, busy_o=0, dropped_count_o=0
REQ-021 pf_ready_o SHALL rise at the first clock edge after rst_i deasserts.
REQ-022 rst_i asserted mid-REQ/WAIT SHALL abandon the outstanding request; no resumption after release.

Verification
REQ-023 Basic issue: push 0x1000_0047 into empty queue -> mem_req_address_o=0x1000_0040, valid two cycles later; ready at +3 -> WAIT; resp -> IDLE, busy_o=0.
REQ-024 Full/backpressure: mem_req_ready_i=0, push 5 distinct lines -> first issued, 4 queued, pf_ready_o=0; push held until one pop; no loss, FIFO order kept.
REQ-025 Duplicate: push 0x2000, 0x2010, 0x2000 -> one fill for 0x2000, dropped_count_o=2.
REQ-026 Cancel: queue 0x3000,0x3040; demand 0x3044 before issue -> only 0x3000 fetched, count=1; demand on outstanding 0x3000 -> count unchanged.
REQ-027 Saturation and simultaneity: preload counter near max, then duplicate push plus cancel same cycle -> +2 increment saturates at 0xFFFF.
REQ-028 Reset mid-WAIT: assert rst_i asynchronously -> outputs zero immediately; pf_ready_o=1 one edge after release; late mem_resp_valid_i ignored.
